// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmitter, receiver and TX arbiter.
package uart_pkg;

    localparam int OVERSAMPLE     = 16;
    localparam int NREQ           = 4;
    localparam int GAP_CYCLES     = OVERSAMPLE;
    // Eleven bit times: a ten-bit frame plus one bit of margin for the transmitter.
    localparam int TIMEOUT_CYCLES = 11 * OVERSAMPLE;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Circular priority search: the first asserted request at or after rr_ptr, searching upward.
module uart_rr_pick #(
    parameter int NREQ = uart_pkg::NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NREQ);

    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        cand  = '0;
        // Scan from the farthest offset to the nearest, so the last hit is the closest to rr_ptr.
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            cand = IDX_W'(pos);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NREQ requesters into a single UART transmitter,
// with a tx_done timeout and an idle gap of GAP_CYCLES after every frame.
module uart_tx_arbiter #(
    parameter int NREQ           = uart_pkg::NREQ,
    parameter int GAP_CYCLES     = uart_pkg::GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES
) (
    input  logic                    clk1,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    active,
    output logic                    timeout_err
);

    import uart_pkg::*;

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e       r_state,       w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr,      w_rr_ptr_nxt;
    logic [CNT_W-1:0] r_cnt,         w_cnt_nxt;
    logic [NREQ-1:0]  r_ack,         w_ack_nxt;
    logic             r_tx_start,    w_tx_start_nxt;
    logic [7:0]       r_tx_data,     w_tx_data_nxt;
    logic [IDX_W-1:0] r_grant_id,    w_grant_id_nxt;
    logic             r_active,      w_active_nxt;
    logic             r_timeout_err, w_timeout_err_nxt;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_ptr_after;
    logic             w_wait_over;

    uart_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx)
    );

    assign w_ptr_after = (r_grant_id == IDX_W'(NREQ - 1)) ? '0 : r_grant_id + IDX_W'(1);
    assign w_wait_over = tx_done || (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // One counter serves both the tx_done timeout and the post-frame gap.
    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_cnt_nxt         = r_cnt;
        w_ack_nxt         = '0;
        w_tx_start_nxt    = 1'b0;
        w_tx_data_nxt     = r_tx_data;
        w_grant_id_nxt    = r_grant_id;
        w_active_nxt      = r_active;
        w_timeout_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_tx_data_nxt         = req_data[{w_pick_idx, 3'b000} +: 8];
                    w_grant_id_nxt        = w_pick_idx;
                    w_ack_nxt[w_pick_idx] = 1'b1;
                    w_active_nxt          = 1'b1;
                    w_state_nxt           = LAUNCH;
                end
            end
            LAUNCH: begin
                w_tx_start_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_state_nxt    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (w_wait_over) begin
                    w_timeout_err_nxt = !tx_done;
                    w_rr_ptr_nxt      = w_ptr_after;
                    w_cnt_nxt         = '0;
                    if (GAP_CYCLES == 0) begin
                        w_active_nxt = 1'b0;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_state_nxt  = GAP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_cnt_nxt    = '0;
                    w_active_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_ack         <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_grant_id    <= '0;
            r_active      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ack         <= w_ack_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_active      <= w_active_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign ack         = r_ack;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign active      = r_active;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int NR   = uart_pkg::NREQ;
    localparam int GAPC = uart_pkg::GAP_CYCLES;
    localparam int TMO  = uart_pkg::TIMEOUT_CYCLES;

    logic            clk1 = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   ack;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_done;
    logic [1:0]      grant_id;
    logic            active;
    logic            timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk1 = ~clk1;

    uart_tx_arbiter dut (
        .clk1        (clk1),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          dly;
        logic [3:0]  exp_ack;
        logic [1:0]  exp_gnt;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        tx_done  = 1'b0;
        tick();
        reset    = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ack"},         ack,         0);
        check({tag, "_tx_start"},    tx_start,    0);
        check({tag, "_tx_data"},     tx_data,     0);
        check({tag, "_grant_id"},    grant_id,    0);
        check({tag, "_active"},      active,      0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic wait_ack(output int n, input int limit);
        n = 0;
        while (ack === '0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Called just after the ack edge: tx_start next, tx_done d cycles later, then the gap.
    task automatic run_txn(input string tag, input int d);
        int n;
        tick();
        check({tag, "_tx_start"}, tx_start, 1);
        repeat (d - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, "_no_timeout"}, timeout_err, 0);
        n = 0;
        while (active === 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check({tag, "_gap_len"}, n, GAPC);
    endtask

    // Reference model: tracks pending requests, the round-robin pointer and the edge at
    // which each transaction ends, and predicts every output cycle by cycle.
    task automatic run_random(input int cycles);
        int            m_ptr, m_free, m_ack_e, m_end_e, m_done_e, m_act_until, m_grant;
        int            e, d, g;
        bit            m_busy, m_to, any, exp_start, exp_to, exp_act;
        bit            pend[NR];
        logic [7:0]    pdat[NR];
        logic [7:0]    m_txd;
        logic [NR-1:0] exp_ack;
        m_ptr = 0;  m_free = cyc + 1;  m_ack_e = -10;  m_end_e = -10;  m_done_e = -1;
        m_act_until = -1;  m_grant = 0;  m_busy = 0;  m_to = 0;  m_txd = 8'h00;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 0;
            pdat[i] = 8'h00;
        end
        for (int t = 0; t < cycles; t++) begin
            e = cyc + 1;
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(3, 0) == 0) begin
                    pend[i] = 1;
                    pdat[i] = 8'($urandom);
                end
                req[i] = pend[i];
                req_data[8*i +: 8] = pend[i] ? pdat[i] : 8'($urandom);
            end
            if (m_busy && e == m_done_e)
                tx_done = 1'b1;
            else if (m_busy && e >= m_ack_e + 2 && e <= m_end_e)
                tx_done = 1'b0;
            else
                tx_done = ($urandom_range(15, 0) == 0);
            exp_ack   = '0;
            exp_start = m_busy && (e == m_ack_e + 1);
            exp_to    = 0;
            if (m_busy && e == m_end_e) begin
                exp_to = m_to;
                m_busy = 0;
                m_ptr  = (m_grant + 1) % NR;
                m_free = e + GAPC + 1;
            end
            any = 0;
            for (int i = 0; i < NR; i++) any |= pend[i];
            if (!m_busy && e >= m_free && any) begin
                g = 0;
                for (int k = 0; k < NR; k++) begin
                    if (pend[(m_ptr + k) % NR]) begin
                        g = (m_ptr + k) % NR;
                        break;
                    end
                end
                exp_ack[g]  = 1'b1;
                m_busy      = 1;
                m_grant     = g;
                m_ack_e     = e;
                m_txd       = pdat[g];
                pend[g]     = 0;
                d           = ($urandom_range(7, 0) == 0) ? TMO + 1 : int'($urandom_range(40, 1));
                m_to        = (d > TMO);
                m_end_e     = e + 1 + (m_to ? TMO : d);
                m_done_e    = m_to ? -1 : m_end_e;
                m_act_until = m_end_e + GAPC - 1;
            end
            exp_act = (e >= m_ack_e) && (e <= m_act_until);
            tick();
            check("rnd_ack",         ack,         exp_ack);
            check("rnd_tx_start",    tx_start,    exp_start);
            check("rnd_timeout_err", timeout_err, exp_to);
            check("rnd_active",      active,      exp_act);
            check("rnd_tx_data",     tx_data,     m_txd);
            if (exp_ack != '0) check("rnd_grant_id", grant_id, m_grant);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] lb_exp[3];
        logic [9:0] line;

        // Grants follow the rr pointer as it moves from reset: 2,0,3,0,0,1,1,2,3(wrap),1.
        vecs[0] = '{4'b0100, 32'h11A52233,  5, 4'b0100, 2'd2, 8'hA5};
        vecs[1] = '{4'b0011, 32'h44556677,  1, 4'b0001, 2'd0, 8'h77};
        vecs[2] = '{4'b1001, 32'h8899AABB, 12, 4'b1000, 2'd3, 8'h88};
        vecs[3] = '{4'b1111, 32'hCCDDEEFF,  3, 4'b0001, 2'd0, 8'hFF};
        vecs[4] = '{4'b0001, 32'h01020304, 30, 4'b0001, 2'd0, 8'h04};
        vecs[5] = '{4'b1110, 32'h05060708,  7, 4'b0010, 2'd1, 8'h07};
        vecs[6] = '{4'b0010, 32'h090A0B0C,  2, 4'b0010, 2'd1, 8'h0B};
        vecs[7] = '{4'b1100, 32'h0D0E0F10, 20, 4'b0100, 2'd2, 8'h0E};
        vecs[8] = '{4'b1000, 32'h12345678,  9, 4'b1000, 2'd3, 8'h12};
        vecs[9] = '{4'b0110, 32'h9ABCDEF0,  4, 4'b0010, 2'd1, 8'hDE};

        do_reset();
        check_reset("por");

        for (int i = 0; i < 10; i++) begin
            req      = vecs[i].req;
            req_data = vecs[i].data;
            tick();
            check("vec_ack",         ack,      vecs[i].exp_ack);
            check("vec_grant",       grant_id, vecs[i].exp_gnt);
            check("vec_tx_data",     tx_data,  vecs[i].exp_txd);
            check("vec_active",      active,   1);
            check("vec_start_early", tx_start, 0);
            req      = '0;
            req_data = 32'($urandom);
            run_txn("vec", vecs[i].dly);
        end

        // All four requesters held: 0,1,2,3,0 with no idle cycle beyond the gap; the fifth frame times out.
        do_reset();
        req      = 4'b1111;
        req_data = 32'h33221100;
        for (int k = 0; k < 5; k++) begin
            wait_ack(n, 400);
            check("rr_idle_to_ack", n, 1);
            check("rr_ack",         ack,      1 << (k % 4));
            check("rr_grant",       grant_id, k % 4);
            check("rr_tx_data",     tx_data,  8'h11 * (k % 4));
            if (k < 4) run_txn("rr", 10);
        end
        req = '0;
        tick();
        check("to_tx_start", tx_start, 1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("to_latency", n, TMO);
        check("to_active", active, 1);
        tick();
        check("to_one_cycle", timeout_err, 0);
        n = 1;
        while (active === 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check("to_gap_len", n, GAPC);

        // Reset during WAIT_DONE: outputs clear, transfer is dropped, rr pointer back to 0.
        req      = 4'b0100;
        req_data = 32'h00770000;
        tick();
        check("pre_ack", ack, 4'b0100);
        req = '0;
        run_txn("pre", 20);
        req      = 4'b1000;
        req_data = 32'h99000000;
        tick();
        check("abort_ack", ack, 4'b1000);
        req = '0;
        tick();
        check("abort_tx_start", tx_start, 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset("midrst");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (3) begin
            tick();
            check("midrst_no_resume_start", tx_start, 0);
            check("midrst_no_resume_active", active, 0);
        end
        req      = 4'b1010;
        req_data = 32'h11002200;
        tick();
        check("post_ack",     ack,      4'b0010);
        check("post_grant",   grant_id, 1);
        check("post_tx_data", tx_data,  8'h22);
        req = '0;
        run_txn("post", 15);

        // req[1] withdrawn before being served; tx_done during the gap is ignored.
        req      = 4'b0001;
        req_data = 32'hCAFE0042;
        tick();
        check("drop_first_ack", ack,     4'b0001);
        check("drop_first_txd", tx_data, 8'h42);
        req      = 4'b1010;
        req_data = 32'h3C005A00;
        tick();
        check("drop_tx_start", tx_start, 1);
        repeat (3) tick();
        req = 4'b1000;
        repeat (5) tick();
        tx_done = 1'b1;
        tick();
        n = 0;
        while (active === 1'b1 && n < 64) begin
            tx_done = (n == 5);
            tick();
            n++;
        end
        tx_done = 1'b0;
        check("drop_gap_len", n, GAPC);
        tick();
        check("drop_ack",     ack,      4'b1000);
        check("drop_grant",   grant_id, 3);
        check("drop_tx_data", tx_data,  8'h3C);
        req = '0;
        run_txn("drop", 12);

        // Loopback: each granted byte framed LSB-first and recovered as a receiver would.
        lb_exp[0] = 8'h00;
        lb_exp[1] = 8'hFF;
        lb_exp[2] = 8'h55;
        req      = 4'b0111;
        req_data = 32'h0055FF00;
        for (int k = 0; k < 3; k++) begin
            wait_ack(n, 400);
            check("lb_ack", ack, 1 << k);
            line = {1'b1, tx_data, 1'b0};
            check("lb_rx_byte", line[8:1], lb_exp[k]);
            req[k] = 1'b0;
            run_txn("lb", 160);
        end

        do_reset();
        check_reset("rnd_rst");
        run_random(4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
